// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Gated frequency counter. Counts rising edges of an
//                asynchronous input over a gate of GATE_CYCLES system clocks.
//                At the end of each gate the count is latched onto freq, and
//                freq_vld pulses for one clock. With the default 1 s gate at
//                100 MHz, the result is in Hz.
//  Build option: FREQ_BCD_EN - when defined, the edge counter is a chain of
//                NDIG BCD decades and freq is packed BCD (4*NDIG bits).
//                When undefined, the edge counter is a CNT_W-bit binary
//                counter.
//  Ports       :
//    clk_100m  in   1        system clock (single domain)
//    cr        in   1        asynchronous active-high reset
//    en        in   1        1 = measure continuously, 0 = idle / abort window
//    sig_in    in   1        asynchronous signal under measurement
//    freq      out  CNT_W    last latched edge count (4*NDIG with FREQ_BCD_EN)
//    freq_vld  out  1        one-cycle pulse, coincident with a freq update
//    ovf       out  1        last latched window saturated the counter
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 27,
    parameter int NDIG        = 8
) (
    input  logic                 clk_100m,
    input  logic                 cr,
    input  logic                 en,
    input  logic                 sig_in,
`ifdef FREQ_BCD_EN
    output logic [4*NDIG-1:0]    freq,
`else
    output logic [CNT_W-1:0]     freq,
`endif
    output logic                 freq_vld,
    output logic                 ovf
);

`ifdef FREQ_BCD_EN
    localparam int c_W = 4 * NDIG;
`else
    localparam int c_W = CNT_W;
`endif

    // GATE_CYCLES-1 always fits in clog2(GATE_CYCLES) bits for GATE_CYCLES >= 2.
    localparam int                  c_GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GATE  = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;

    // Configurations below these minimums are not supported; the counters
    // and gate compare assume them.
    generate
        if (GATE_CYCLES < 2 || CNT_W < 1 || NDIG < 1) begin : g_unsupported_cfg
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronizer (s1, s2) plus delay flop (s3) for edge detection
    // ------------------------------------------------------------------
    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic w_rise;

    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign w_rise = s2_q & ~s3_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [c_GATE_W-1:0] gate_cnt_q;
    logic [c_GATE_W-1:0] gate_cnt_d;
    logic                w_gate_end;
    logic                w_count_en;
    logic                w_load;

    assign w_gate_end = (gate_cnt_q == c_GATE_LAST);

    // State register
    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (en) begin
                    state_d = c_ST_GATE;
                end
            end
            c_ST_GATE: begin
                if (!en) begin
                    state_d = c_ST_IDLE;
                end else if (w_gate_end) begin
                    state_d = c_ST_LATCH;
                end
            end
            c_ST_LATCH: begin
                state_d = en ? c_ST_GATE : c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        freq_vld   = (state_q == c_ST_LATCH);
        // An en drop in GATE aborts the window in that same cycle, so that
        // cycle neither counts nor latches.
        w_count_en = (state_q == c_ST_GATE) && en;
        w_load     = w_count_en && w_gate_end;
    end

    // ------------------------------------------------------------------
    // Gate counter: runs only while counting; cleared otherwise
    // ------------------------------------------------------------------
    always_comb begin
        gate_cnt_d = '0;
        if (w_count_en && !w_gate_end) begin
            gate_cnt_d = gate_cnt_q + c_GATE_W'(1);
        end
    end

    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) begin
            gate_cnt_q <= '0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Edge counter increment / full detection
    // ------------------------------------------------------------------
    logic [c_W-1:0] edge_cnt_q;
    logic [c_W-1:0] edge_cnt_d;
    logic [c_W-1:0] w_cnt_inc;
    logic           w_cnt_full;
    logic           sat_q;
    logic           sat_d;

`ifdef FREQ_BCD_EN
    // Ripple-carry chain of decades: a digit advances when every lower
    // digit is 9. Carry out of the top digit means the counter is all 9s.
    logic [NDIG:0] w_carry;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_digit
            logic w_is9;
            assign w_is9          = (edge_cnt_q[4*i +: 4] == 4'd9);
            assign w_carry[i+1]   = w_carry[i] & w_is9;
            assign w_cnt_inc[4*i +: 4] = !w_carry[i] ? edge_cnt_q[4*i +: 4] :
                                         w_is9       ? 4'd0 :
                                                       edge_cnt_q[4*i +: 4] + 4'd1;
        end
    endgenerate

    assign w_cnt_full = w_carry[NDIG];
`else
    assign w_cnt_inc  = edge_cnt_q + c_W'(1);
    assign w_cnt_full = &edge_cnt_q;
`endif

    // A rise arriving while the counter is full is the lost edge that marks
    // the window as saturated; the count itself holds and never wraps.
    always_comb begin
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (w_count_en) begin
            edge_cnt_d = edge_cnt_q;
            sat_d      = sat_q;
            if (w_rise) begin
                if (w_cnt_full) begin
                    sat_d = 1'b1;
                end else begin
                    edge_cnt_d = w_cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) begin
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    // Loaded on the edge that enters LATCH, from the next-count value so the
    // final gate cycle's rise is included. This makes freq change on the
    // same edge that raises freq_vld.
    logic [c_W-1:0] freq_q;
    logic           ovf_q;

    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) begin
            freq_q <= '0;
            ovf_q  <= 1'b0;
        end else if (w_load) begin
            freq_q <= edge_cnt_d;
            ovf_q  <= sat_d;
        end
    end

    assign freq = freq_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Self-checking bench for freq_meter. Two instances share one
//                stimulus: a wide one (A) and a narrow one (B, 4-bit result)
//                that saturates. A window-level reference model predicts
//                freq / freq_vld / ovf every cycle; directed checks pin the
//                model with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    localparam int GC = 100;

`ifdef FREQ_BCD_EN
    localparam int     AW    = 32;
    localparam int     BW    = 4;
    localparam longint A_MAX = 99999999;
    localparam longint B_MAX = 9;
    localparam logic [31:0] A0  = 32'h0;
    localparam logic [31:0] A10 = 32'h10;
    localparam logic [31:0] A25 = 32'h25;
    localparam logic [31:0] A50 = 32'h50;
    localparam logic [31:0] B10 = 32'h9;
    localparam logic [31:0] B10_OVF = 32'd1;
    localparam logic [31:0] B_SAT = 32'h9;
`else
    localparam int     AW    = 27;
    localparam int     BW    = 4;
    localparam longint A_MAX = 134217727;
    localparam longint B_MAX = 15;
    localparam logic [31:0] A0  = 32'd0;
    localparam logic [31:0] A10 = 32'd10;
    localparam logic [31:0] A25 = 32'd25;
    localparam logic [31:0] A50 = 32'd50;
    localparam logic [31:0] B10 = 32'd10;
    localparam logic [31:0] B10_OVF = 32'd0;
    localparam logic [31:0] B_SAT = 32'd15;
`endif

    logic clk = 1'b0;
    logic cr = 1'b1;
    logic en = 1'b0;
    logic sig_in = 1'b0;

    logic [AW-1:0] a_freq;
    logic          a_vld;
    logic          a_ovf;
    logic [BW-1:0] b_freq;
    logic          b_vld;
    logic          b_ovf;

    int n_checks = 0;
    int n_err = 0;
    int hp = 0;       // half period of sig_in in clocks; 0 holds sig_in constant

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(27), .NDIG(8)) u_a (
        .clk_100m(clk), .cr(cr), .en(en), .sig_in(sig_in),
        .freq(a_freq), .freq_vld(a_vld), .ovf(a_ovf)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .NDIG(1)) u_b (
        .clk_100m(clk), .cr(cr), .en(en), .sig_in(sig_in),
        .freq(b_freq), .freq_vld(b_vld), .ovf(b_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Saturate a true edge count to the counter's range and encode it.
    function automatic logic [31:0] enc(input longint n, input longint mx);
        longint v;
        logic [31:0] r;
        v = (n > mx) ? mx : n;
        r = '0;
`ifdef FREQ_BCD_EN
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
`else
        r = 32'(v);
`endif
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a window is GC consecutive enabled clocks; the
    // edges it contains are the sig_in rises visible to the counter, which
    // sees sig_in as sampled two and three clocks earlier. The raw count is
    // kept unsaturated and clipped only when the window closes.
    // ------------------------------------------------------------------
    int          m_phase;     // -1 idle, 0..GC-1 position in window, GC = result cycle
    longint      m_edges;
    logic [3:1]  hist;        // hist[k] = sig_in sampled k edges ago
    logic        e_vld;
    logic [31:0] ea_freq;
    logic        ea_ovf;
    logic [31:0] eb_freq;
    logic        eb_ovf;

    always @(posedge clk or posedge cr) begin
        if (cr) begin
            m_phase <= -1;
            m_edges <= 0;
            hist    <= '0;
            e_vld   <= 1'b0;
            ea_freq <= '0;
            ea_ovf  <= 1'b0;
            eb_freq <= '0;
            eb_ovf  <= 1'b0;
        end else begin
            hist  <= {hist[2:1], sig_in};
            e_vld <= 1'b0;
            if (m_phase < 0) begin
                if (en) begin
                    m_phase <= 0;
                    m_edges <= 0;
                end
            end else if (m_phase < GC) begin
                if (!en) begin
                    m_phase <= -1;
                end else if (m_phase == GC - 1) begin
                    m_phase <= GC;
                    e_vld   <= 1'b1;
                    ea_freq <= enc(m_edges + longint'(hist[2] & ~hist[3]), A_MAX);
                    ea_ovf  <= (m_edges + longint'(hist[2] & ~hist[3])) > A_MAX;
                    eb_freq <= enc(m_edges + longint'(hist[2] & ~hist[3]), B_MAX);
                    eb_ovf  <= (m_edges + longint'(hist[2] & ~hist[3])) > B_MAX;
                end else begin
                    m_phase <= m_phase + 1;
                    m_edges <= m_edges + longint'(hist[2] & ~hist[3]);
                end
            end else begin
                m_phase <= en ? 0 : -1;
                m_edges <= 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!cr) begin
            chk("a_vld", 32'(a_vld), 32'(e_vld));
            chk("a_freq", 32'(a_freq), ea_freq);
            chk("a_ovf", 32'(a_ovf), 32'(ea_ovf));
            chk("b_vld", 32'(b_vld), 32'(e_vld));
            chk("b_freq", 32'(b_freq), eb_freq);
            chk("b_ovf", 32'(b_ovf), 32'(eb_ovf));
        end
    end

    // sig_in generator
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (hp == 0) begin
                ph = 0;
            end else begin
                ph++;
                if (ph >= hp) begin
                    sig_in = ~sig_in;
                    ph = 0;
                end
            end
        end
    end

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_vld && n < 400);
        if (!a_vld) begin
            n_checks++;
            n_err++;
            $display("FAIL pulse_timeout actual=no_pulse required=pulse t=%0t", $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int n;
        int pulses;

        // Reset state
        wait_cycles(3);
        chk("rst_freq", 32'(a_freq), 32'd0);
        chk("rst_vld", 32'(a_vld), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        cr = 1'b0;

        // Period 10: five windows of 10, spaced 101 clocks
        en = 1'b1;
        hp = 5;
        wait_pulse(n);
        for (int w = 0; w < 5; w++) begin
            wait_pulse(n);
            chk("p10_period", 32'(n), 32'd101);
            chk("p10_freq", 32'(a_freq), A10);
            chk("p10_ovf", 32'(a_ovf), 32'd0);
            chk("p10_b_freq", 32'(b_freq), B10);
            chk("p10_b_ovf", 32'(b_ovf), B10_OVF);
        end

        // Asynchronous reset mid-gate with edges running
        wait_cycles(30);
        chk("pre_rst_freq", 32'(a_freq), A10);
        #2 cr = 1'b1;
        #1;
        chk("mid_rst_freq", 32'(a_freq), 32'd0);
        chk("mid_rst_vld", 32'(a_vld), 32'd0);
        chk("mid_rst_ovf", 32'(a_ovf), 32'd0);
        chk("mid_rst_b_freq", 32'(b_freq), 32'd0);
        wait_cycles(2);
        en = 1'b0;
        cr = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (a_vld) pulses++;
        end
        chk("idle_no_vld", 32'(pulses), 32'd0);

        // Period 4 -> 25
        hp = 2;
        en = 1'b1;
        wait_pulse(n);
        wait_pulse(n);
        chk("p4_period", 32'(n), 32'd101);
        chk("p4_freq", 32'(a_freq), A25);
        chk("p4_ovf", 32'(a_ovf), 32'd0);
        chk("p4_b_freq", 32'(b_freq), B_SAT);
        chk("p4_b_ovf", 32'(b_ovf), 32'd1);

        // Constant input -> 0
        hp = 0;
        wait_pulse(n);
        wait_pulse(n);
        chk("dc_freq", 32'(a_freq), A0);
        chk("dc_b_freq", 32'(b_freq), 32'd0);
        chk("dc_b_ovf", 32'(b_ovf), 32'd0);

        // Period 2 -> 50 edges: saturates the narrow instance
        hp = 1;
        wait_pulse(n);
        wait_pulse(n);
        chk("p2_freq", 32'(a_freq), A50);
        chk("p2_ovf", 32'(a_ovf), 32'd0);
        chk("p2_b_freq", 32'(b_freq), B_SAT);
        chk("p2_b_ovf", 32'(b_ovf), 32'd1);

        // Back to period 10: saturation does not stick
        hp = 5;
        wait_pulse(n);
        wait_pulse(n);
        chk("rec_b_freq", 32'(b_freq), B10);
        chk("rec_b_ovf", 32'(b_ovf), B10_OVF);

        // Abort at gate cycle 50
        wait_cycles(50);
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_vld) pulses++;
        end
        chk("abort_no_vld", 32'(pulses), 32'd0);
        chk("abort_freq_hold", 32'(a_freq), A10);

        // Re-enable with period 4
        hp = 2;
        wait_cycles(10);
        en = 1'b1;
        wait_pulse(n);
        chk("reen_latency", 32'(n), 32'd101);
        chk("reen_freq", 32'(a_freq), A25);
        wait_cycles(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
